// File: rtl/buzzer_arbiter_if.sv
// rtl/buzzer_arbiter_if.sv - note-source request bus and arbitrated buzzer outputs
interface buzzer_arbiter_if;
    logic       pause;
    logic [2:0] req;
    logic [4:0] note0;
    logic [4:0] note1;
    logic [4:0] note2;
    logic [4:0] note_out;
    logic [2:0] grant;
    logic       busy;

    modport master (
        output pause, req, note0, note1, note2,
        input  note_out, grant, busy
    );

    modport slave (
        input  pause, req, note0, note1, note2,
        output note_out, grant, busy
    );
endinterface

// File: rtl/buzzer_arbiter.sv
// rtl/buzzer_arbiter.sv - three-source buzzer arbiter with hold time and articulation gap
// Define BUZZER_ARB_RR_EN for round-robin selection without preemption.
module buzzer_arbiter #(
    parameter int GAP_CYCLES = 2_500_000,
    parameter int MIN_HOLD   = 5_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    buzzer_arbiter_if.slave   bus
);
    localparam int HW = $clog2(MIN_HOLD + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

    state_t          state_q;
    logic [4:0]      note_q;
    logic [2:0]      grant_q;
    logic            busy_q;
    logic [HW-1:0]   hold_cnt_q;
    logic [GW-1:0]   gap_cnt_q;
`ifdef BUZZER_ARB_RR_EN
    logic [1:0]      rr_ptr_q;
`endif

    logic [2:0] active;
    logic       win_valid;
    logic [1:0] win_idx;
    logic [4:0] win_note;
    logic [4:0] owner_note;
    logic       owner_req;
    logic       release_ev;
    logic       change_ev;
    logic       preempt_ev;
    logic       hold_done;

    assign active = bus.req & {bus.note2 != 5'd0, bus.note1 != 5'd0, bus.note0 != 5'd0};

    always_comb begin
`ifdef BUZZER_ARB_RR_EN
        logic [2:0] pos;
        pos       = 3'd0;
`endif
        win_valid = 1'b0;
        win_idx   = 2'd0;
        // Scan from the least preferred candidate so the preferred one is assigned last.
        for (int k = 2; k >= 0; k--) begin
`ifdef BUZZER_ARB_RR_EN
            pos = {1'b0, rr_ptr_q} + 3'(k);
            if (pos >= 3'd3) pos = pos - 3'd3;
            if (active[pos[1:0]]) begin
                win_valid = 1'b1;
                win_idx   = pos[1:0];
            end
`else
            if (active[k]) begin
                win_valid = 1'b1;
                win_idx   = 2'(k);
            end
`endif
        end
    end

    always_comb begin
        win_note = 5'd0;
        case (win_idx)
            2'd0:    win_note = bus.note0;
            2'd1:    win_note = bus.note1;
            default: win_note = bus.note2;
        endcase
    end

    always_comb begin
        owner_note = 5'd0;
        case (grant_q)
            3'b001:  owner_note = bus.note0;
            3'b010:  owner_note = bus.note1;
            3'b100:  owner_note = bus.note2;
            default: owner_note = 5'd0;
        endcase
    end

    assign owner_req  = |(bus.req & grant_q);
    assign release_ev = !owner_req || (owner_note == 5'd0);
    assign change_ev  = owner_note != note_q;
`ifdef BUZZER_ARB_RR_EN
    assign preempt_ev = 1'b0;
`else
    // grant_q - 1 masks exactly the indices below the one-hot owner.
    assign preempt_ev = |(active & (grant_q - 3'd1));
`endif
    assign hold_done  = hold_cnt_q == HW'(MIN_HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            note_q     <= 5'd0;
            grant_q    <= 3'd0;
            busy_q     <= 1'b0;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
`ifdef BUZZER_ARB_RR_EN
            rr_ptr_q   <= 2'd0;
`endif
        end else if (bus.pause) begin
            state_q    <= S_IDLE;
            note_q     <= 5'd0;
            grant_q    <= 3'd0;
            busy_q     <= 1'b0;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_GAP: begin
                    if (state_q == S_GAP && gap_cnt_q != GW'(GAP_CYCLES - 1)) begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end else if (win_valid) begin
                        state_q    <= S_PLAY;
                        note_q     <= win_note;
                        grant_q    <= 3'b001 << win_idx;
                        busy_q     <= 1'b1;
                        hold_cnt_q <= '0;
                        gap_cnt_q  <= '0;
`ifdef BUZZER_ARB_RR_EN
                        rr_ptr_q   <= (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
`endif
                    end else begin
                        state_q   <= S_IDLE;
                        note_q    <= 5'd0;
                        grant_q   <= 3'd0;
                        busy_q    <= 1'b0;
                        gap_cnt_q <= '0;
                    end
                end
                S_PLAY: begin
                    if (!hold_done) hold_cnt_q <= hold_cnt_q + 1'b1;
                    if (hold_done && (release_ev || change_ev || preempt_ev)) begin
                        state_q    <= S_GAP;
                        note_q     <= 5'd0;
                        grant_q    <= 3'd0;
                        gap_cnt_q  <= '0;
                        hold_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    note_q  <= 5'd0;
                    grant_q <= 3'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.note_out = note_q;
    assign bus.grant    = grant_q;
    assign bus.busy     = busy_q;
endmodule
